// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic multiplier array.
// Holds the FSM state enum, the WIDTH range and the LFSR tap table.
package sc_pkg;

  localparam int W_MIN = 4;
  localparam int W_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_t;

  // Fibonacci taps, bit t-1 set for tap t,
  // feedback shifted into bit 0.
  function automatic logic [15:0] sc_taps(input int w);
    logic [15:0] t;
    t = 16'h0000;
    unique case (w)
      4:  t = 16'h000C;
      5:  t = 16'h0014;
      6:  t = 16'h0030;
      7:  t = 16'h0060;
      8:  t = 16'h00B8;
      9:  t = 16'h0110;
      10: t = 16'h0240;
      11: t = 16'h0500;
      12: t = 16'h0829;
      13: t = 16'h100D;
      14: t = 16'h2015;
      15: t = 16'h6000;
      16: t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sc_mult_array_if.sv
// Operand/result handshake bundle for sc_mult_array.
// master drives operands + out_ready; slave returns ready/results/busy.
interface sc_mult_array_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*WIDTH-1:0] op_a;
  logic [CHANNELS*WIDTH-1:0] op_b;
  logic                      bipolar;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS*WIDTH-1:0] result;
  logic                      busy;

  modport master (
    output in_valid, op_a, op_b, bipolar, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, bipolar, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR shared by all lanes.
// Ports: clk, rst_n, load (reload SEED), step (advance), state.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(sc_taps(WIDTH));

  logic fb;
  assign fb = ^(state & TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/sc_mult_array.sv
// CHANNELS-lane stochastic multiplier; counts product ones over 2^WIDTH-1 cycles.
// Ports: clk, rst_n, ena, bus (slave). Macro SC_BIPOLAR_EN enables XNOR mode.
module sc_mult_array
  import sc_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               CHANNELS = 2,
  parameter logic [WIDTH-1:0] SEED     = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  sc_mult_array_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST = {WIDTH{1'b1}} - WIDTH'(1);

  sc_state_t        state;
  logic [WIDTH-1:0] cyc;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_rev;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             accept;
  logic             sample;
  logic             last;

  assign accept = ena & bus.in_valid & (state == IDLE);
  assign sample = ena & (state == RUN);
  assign last   = sample & (cyc == LAST);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  always_comb begin
    lfsr_rev = '0;
    for (int k = 0; k < WIDTH; k++) begin
      lfsr_rev[k] = lfsr[WIDTH-1-k];
    end
  end

  sc_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (sample),
    .state (lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cyc         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= RUN;
            cyc        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (ena) begin
            cyc <= cyc + WIDTH'(1);
            if (cyc == LAST) begin
              state       <= DONE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (ena && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SC_BIPOLAR_EN
  logic bip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bip_q <= 1'b0;
    end else if (accept) begin
      bip_q <= bus.bipolar;
    end
  end
`else
  logic unused_bipolar;
  assign unused_bipolar = bus.bipolar;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] res_q;
    logic             sa;
    logic             sb;
    logic             prod;

    // Bit-reversed state decorrelates the B stream from A.
    assign sa = (lfsr <= a_q);
    assign sb = (lfsr_rev <= b_q);
`ifdef SC_BIPOLAR_EN
    assign prod = bip_q ? ~(sa ^ sb) : (sa & sb);
`else
    assign prod = sa & sb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q   <= '0;
        b_q   <= '0;
        cnt   <= '0;
        res_q <= '0;
      end else if (accept) begin
        a_q <= bus.op_a[i*WIDTH +: WIDTH];
        b_q <= bus.op_b[i*WIDTH +: WIDTH];
        cnt <= '0;
      end else if (sample) begin
        cnt <= cnt + WIDTH'(prod);
        if (last) begin
          res_q <= cnt + WIDTH'(prod);
        end
      end
    end

    assign bus.result[i*WIDTH +: WIDTH] = res_q;
  end

endmodule

// File: tb/tb_sc_mult_array.sv
// Directed scoreboard bench for sc_mult_array (WIDTH=8, CHANNELS=2).
// Covers exact counts, latency, backpressure, ena stalls and mid-run reset.
module tb_sc_mult_array;

  localparam int W = 8;
  localparam int C = 2;
  localparam int N = 255;

  typedef struct packed {
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic         c1;
  } exp_t;

  logic clk;
  logic rst_n;
  logic ena;

  sc_mult_array_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  sc_mult_array #(
    .WIDTH    (W),
    .CHANNELS (C),
    .SEED     (8'd1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [W-1:0] r_ref;
  logic [W-1:0] r_tmp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input logic [W-1:0] obs,
                         input int lo, input int hi);
    n_assert++;
    assert ((int'(obs) >= lo) && (int'(obs) <= hi)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set, wait for results, compare against the queue.
  task automatic run(input string tag,
                     input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input logic bip,
                     input logic [W-1:0] e0, input logic [W-1:0] e1,
                     input logic c1,
                     input int stall_at, input int stall_len,
                     input int exp_lat, input bit rel,
                     output logic [W-1:0] lane1);
    exp_t e;
    int   n;
    sb.push_back('{e0: e0, e1: e1, c1: c1});
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.op_a     = {a1, a0};
    bus.op_b     = {b1, b0};
    bus.bipolar  = bip;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 1000) begin
      ena = !(n >= stall_at && n < stall_at + stall_len);
      tick();
      n++;
    end
    ena = 1'b1;
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    e = sb.pop_front();
    chk({tag, "_lane0"}, 32'(bus.result[0 +: W]), 32'(e.e0));
    if (e.c1) begin
      chk({tag, "_lane1"}, 32'(bus.result[W +: W]), 32'(e.e1));
    end else begin
      chk_rng({tag, "_lane1_rng"}, bus.result[W +: W], 48, 80);
    end
    lane1 = bus.result[W +: W];
    if (rel) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_rel_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_rel_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_hold_lane0"}, 32'(bus.result[0 +: W]), 32'(e.e0));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.bipolar   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run("u255x100", 8'd255, 8'd100, 8'd128, 8'd128, 1'b0,
        8'd100, 8'd0, 1'b0, 9999, 0, N, 1'b1, r_ref);

    run("u0x200", 8'd0, 8'd200, 8'd128, 8'd128, 1'b0,
        8'd0, r_ref, 1'b1, 9999, 0, N, 1'b1, r_tmp);

    run("u255x255", 8'd255, 8'd255, 8'd0, 8'd0, 1'b0,
        8'd255, 8'd0, 1'b1, 9999, 0, N, 1'b1, r_tmp);

`ifdef SC_BIPOLAR_EN
    run("b255_0", 8'd255, 8'd255, 8'd0, 8'd255, 1'b1,
        8'd255, 8'd0, 1'b1, 9999, 0, N, 1'b1, r_tmp);
    run("b0x0", 8'd0, 8'd0, 8'd0, 8'd0, 1'b1,
        8'd255, 8'd255, 1'b1, 9999, 0, N, 1'b1, r_tmp);
`else
    run("nb255_0", 8'd255, 8'd255, 8'd0, 8'd255, 1'b1,
        8'd255, 8'd0, 1'b1, 9999, 0, N, 1'b1, r_tmp);
    run("nb0x0", 8'd0, 8'd0, 8'd0, 8'd0, 1'b1,
        8'd0, 8'd0, 1'b1, 9999, 0, N, 1'b1, r_tmp);
`endif

    // Backpressure: hold DONE while new operands are offered.
    run("bp", 8'd255, 8'd100, 8'd255, 8'd50, 1'b0,
        8'd100, 8'd50, 1'b1, 9999, 0, N, 1'b0, r_tmp);
    bus.op_a     = 16'h0101;
    bus.op_b     = 16'h0202;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_result", 32'(bus.result), 32'h3264);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_rel_result", 32'(bus.result), 32'h3264);

    // Clock-enable stall of 10 cycles mid-run.
    run("ena", 8'd255, 8'd100, 8'd128, 8'd128, 1'b0,
        8'd100, r_ref, 1'b1, 100, 10, N + 10, 1'b1, r_tmp);

    // Reset at RUN sample 50, then a clean rerun.
    bus.op_a     = {8'd128, 8'd255};
    bus.op_b     = {8'd128, 8'd100};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (50) tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run("post_rst", 8'd255, 8'd100, 8'd128, 8'd128, 1'b0,
        8'd100, r_ref, 1'b1, 9999, 0, N, 1'b1, r_tmp);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
